cpu_mem_responder: RTL

CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

---
 rtl/cpu_mem_responder.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/cpu_mem_responder.sv
// -----------------------------------------------------------------------------
// cpu_mem_responder
//   Memory-side companion for a small single-cycle CPU. After reset it is in
//   LOAD: a program loader streams instruction words into imem while the CPU
//   is held in reset. The last word (ld_last, or a full imem) switches it to
//   RUN. In RUN the CPU is released and sees:
//     - instruction fetch from imem, combinational read;
//     - data load/store to dmem, with an async read and a sync write;
//     - memory-mapped LED register (0xFFFF_FFF0) and cycle counter
//       (0xFFFF_FFF4) in the 0xF region.
//
// Ports
//   clk          in   1   single clock, rising edge
//   rst          in   1   asynchronous, active-low reset
//   pc           in  32   CPU fetch byte address
//   instr        out 32   instruction word for pc (0 while loading)
//   memwrite     in   1   CPU store strobe
//   addr         in  32   CPU data byte address
//   writedata    in  32   CPU store data
//   readdata     out 32   CPU load data
//   ld_valid     in   1   loader word valid
//   ld_data      in  32   loader instruction word
//   ld_last      in   1   loader final word marker
//   ld_ready     out  1   loader word accepted (LOAD state)
//   cpu_rst      out  1   active-high reset to CPU (LOAD state)
//   led          out 16   LED register
//   misalign_err out  1   sticky misaligned-store flag
// -----------------------------------------------------------------------------
module cpu_mem_responder #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        cpu_rst,
  output logic [15:0] led,
  output logic        misalign_err
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);
  localparam logic [IAW-1:0] LD_PTR_LAST = IAW'(IMEM_DEPTH - 1);
  localparam logic [31:0] MMIO_LED = 32'hFFFF_FFF0;
  localparam logic [31:0] MMIO_CNT = 32'hFFFF_FFF4;

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  logic [IAW-1:0]  r_ld_ptr;
  logic            r_cpu_rst;
  logic            r_ld_ready;
  logic [15:0]     r_led;
  logic [31:0]     r_cycle_cnt;
  logic            r_misalign;
  logic [31:0]     r_imem [IMEM_DEPTH];
  logic [31:0]     r_dmem [DMEM_DEPTH];

  logic            w_run;
  logic            w_ld_accept;
  logic            w_ld_done;
  logic            w_is_mmio;
  logic            w_aligned;
  logic            w_dmem_we;
  logic            w_led_we;
  logic            w_misalign_set;
  logic [IAW-1:0]  w_imem_idx;
  logic [DAW-1:0]  w_dmem_idx;
  logic [31:0]     w_readdata;
  logic            w_unused_pc;

  assign w_run          = (r_state == ST_RUN);
  assign w_ld_accept    = (r_state == ST_LOAD) && ld_valid;
  // Leave LOAD on an explicit last word or when the final imem slot is filled.
  assign w_ld_done      = w_ld_accept && (ld_last || (r_ld_ptr == LD_PTR_LAST));
  assign w_is_mmio      = (addr[31:28] == 4'hF);
  assign w_aligned      = (addr[1:0] == 2'b00);
  assign w_dmem_we      = w_run && memwrite && w_aligned && !w_is_mmio;
  assign w_led_we       = w_run && memwrite && (addr == MMIO_LED);
  assign w_misalign_set = w_run && memwrite && !w_aligned;
  assign w_imem_idx     = pc[IAW+1:2];
  assign w_dmem_idx     = addr[DAW+1:2];
  assign w_unused_pc    = &{1'b0, pc[31:IAW+2], pc[1:0]};

  // Load/run sequencing with registered loader handshake and CPU reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_LOAD;
      r_ld_ptr   <= '0;
      r_cpu_rst  <= 1'b1;
      r_ld_ready <= 1'b1;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_ld_accept) begin
            r_ld_ptr <= r_ld_ptr + 1'b1;
          end
          if (w_ld_done) begin
            r_state    <= ST_RUN;
            r_cpu_rst  <= 1'b0;
            r_ld_ready <= 1'b0;
          end
        end
        ST_RUN: begin
          r_state    <= ST_RUN;
          r_cpu_rst  <= 1'b0;
          r_ld_ready <= 1'b0;
        end
        default: begin
          r_state    <= ST_LOAD;
          r_ld_ptr   <= '0;
          r_cpu_rst  <= 1'b1;
          r_ld_ready <= 1'b1;
        end
      endcase
    end
  end

  // LED register, free-running RUN cycle counter and sticky misalign flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_led       <= 16'h0000;
      r_cycle_cnt <= 32'h0000_0000;
      r_misalign  <= 1'b0;
    end else begin
      if (w_led_we) begin
        r_led <= writedata[15:0];
      end
      if (w_run) begin
        r_cycle_cnt <= r_cycle_cnt + 32'h0000_0001;
      end
      if (w_misalign_set) begin
        r_misalign <= 1'b1;
      end
    end
  end

  // Instruction memory write port (contents survive reset).
  always_ff @(posedge clk) begin
    if (w_ld_accept) begin
      r_imem[r_ld_ptr] <= ld_data;
    end
  end

  // Data memory write port (contents survive reset).
  always_ff @(posedge clk) begin
    if (w_dmem_we) begin
      r_dmem[w_dmem_idx] <= writedata;
    end
  end

  // Load data mux: dmem for the data region, MMIO decode for the 0xF region.
  always_comb begin
    w_readdata = 32'h0000_0000;
    if (!w_is_mmio) begin
      w_readdata = r_dmem[w_dmem_idx];
    end else if (addr == MMIO_LED) begin
      w_readdata = {16'h0000, r_led};
    end else if (addr == MMIO_CNT) begin
      w_readdata = r_cycle_cnt;
    end else begin
      w_readdata = 32'h0000_0000;
    end
  end

  assign readdata     = w_readdata;
  assign instr        = w_run ? r_imem[w_imem_idx] : 32'h0000_0000;
  assign ld_ready     = r_ld_ready;
  assign cpu_rst      = r_cpu_rst;
  assign led          = r_led;
  assign misalign_err = r_misalign;

endmodule
